// File: rtl/dl_pkg.sv
// ----------------------------------------------------------------------------
// dl_pkg
// Shared types and constants for the ioctl download sequencer.
//   dl_state_t   : sequencer states
//   IDX_*        : ioctl stream indices handled by the sequencer
//   MOD_*        : machine-variant codes decoded from the index-1 byte
//   hold_width() : counter width needed to count HOLD_CYCLES-1 down to 0
// ----------------------------------------------------------------------------
package dl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_ROM,
        LOAD_AUX,
        HOLD,
        RUN
    } dl_state_t;

    localparam logic [7:0] IDX_ROM  = 8'd0;
    localparam logic [7:0] IDX_MOD  = 8'd1;
    localparam logic [7:0] IDX_DIP  = 8'd254;

    localparam logic [7:0] MOD_SBAG = 8'd1;
    localparam logic [7:0] MOD_PICK = 8'd2;

    localparam logic [16:0] BYTE_COUNT_MAX = 17'h1FFFF;

    // At least one bit, so HOLD_CYCLES == 1 still yields a legal counter.
    function automatic int unsigned hold_width(input int unsigned cycles);
        return (cycles > 1) ? $clog2(cycles) : 1;
    endfunction

endpackage

// File: rtl/dl_hold_timer.sv
// ----------------------------------------------------------------------------
// dl_hold_timer
// Loadable down-counter that stretches the game-core reset. It starts (and
// reloads) at HOLD_CYCLES-1 and counts down to zero while enabled.
// Ports:
//   clock_12mhz : system clock
//   reset       : asynchronous, active-high; counter returns to HOLD_CYCLES-1
//   load        : reload the counter with HOLD_CYCLES-1 (wins over en)
//   en          : decrement by one this cycle (stops at zero)
//   done        : counter is zero
// ----------------------------------------------------------------------------
module dl_hold_timer
    import dl_pkg::*;
#(
    parameter int HOLD_CYCLES = 1024
) (
    input  logic clock_12mhz,
    input  logic reset,
    input  logic load,
    input  logic en,
    output logic done
);

    localparam int unsigned CW = hold_width(HOLD_CYCLES);
    localparam logic [CW-1:0] START = CW'(HOLD_CYCLES - 1);

    logic [CW-1:0] count;

    // NOTE: sequential state is written with non-blocking assignments only, so
    // every register samples the pre-edge values regardless of block order.
    always_ff @(posedge clock_12mhz or posedge reset) begin
        if (reset) begin
            count <= START;
        end else if (load) begin
            count <= START;
        end else if (en && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign done = (count == '0);

endmodule

// File: rtl/rom_download_ctrl.sv
// ----------------------------------------------------------------------------
// rom_download_ctrl
// Sequences the hps_io ioctl download stream for the arcade core: index-0
// bytes go to the core ROM/RAM write port, index 1 sets the machine variant,
// index 254 fills the DIP bank. The core is held in reset during a ROM load
// and for HOLD_CYCLES cycles afterwards (and after reset).
//
// Optional feature: define ROM_CHECKSUM_EN to add a 16-bit running sum of the
// accepted ROM bytes, compared against EXPECTED_SUM at the end of a load.
//
// Ports:
//   clock_12mhz    : system clock
//   reset          : asynchronous, active-high
//   ioctl_download : download active
//   ioctl_wr       : byte strobe
//   ioctl_addr     : byte address (25 bits)
//   ioctl_dout     : byte data
//   ioctl_index    : stream index, latched when ioctl_download rises
//   dn_addr/dn_data/dn_wr : ROM write port, one-cycle strobe per byte
//   core_reset     : reset to the game core
//   mod            : machine-variant byte; mod_sbag / mod_pick decode it
//   dipsw          : DIP bank, byte n at bits [8n+7:8n]
//   rom_err        : sticky out-of-range ROM address flag
//   byte_count     : accepted ROM bytes in the current/last load (saturating)
//   sum_ok         : checksum match (always 0 without ROM_CHECKSUM_EN)
// ----------------------------------------------------------------------------
module rom_download_ctrl
    import dl_pkg::*;
#(
    parameter logic [16:0] ROM_SIZE     = 17'h14000,
    parameter int          HOLD_CYCLES  = 1024,
    parameter logic [15:0] EXPECTED_SUM = 16'h0000
) (
    input  logic        clock_12mhz,
    input  logic        reset,
    input  logic        ioctl_download,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    input  logic [7:0]  ioctl_index,
    output logic [16:0] dn_addr,
    output logic [7:0]  dn_data,
    output logic        dn_wr,
    output logic        core_reset,
    output logic [7:0]  mod,
    output logic        mod_sbag,
    output logic        mod_pick,
    output logic [63:0] dipsw,
    output logic        rom_err,
    output logic [16:0] byte_count,
    output logic        sum_ok
);

    dl_state_t   state;
    dl_state_t   ret_state;   // where a download was started from
    logic        dl_prev;
    logic [7:0]  idx_q;

    logic        dl_rise;
    logic        dl_fall;
    logic        can_start;
    logic        start_rom;
    logic        start_aux;
    logic        rom_active;
    logic        aux_active;
    logic [7:0]  wr_idx;
    logic        rom_accept;
    logic        rom_reject;
    logic        rom_end;
    logic        rom_to_idle;
    logic        hold_done;
    logic [16:0] count_next;
    logic        err_next;

    assign dl_rise   = ioctl_download & ~dl_prev;
    assign dl_fall   = ~ioctl_download & dl_prev;
    assign can_start = (state == RUN) || (state == IDLE) || (state == HOLD);
    assign start_rom = dl_rise && can_start && (ioctl_index == IDX_ROM);
    assign start_aux = dl_rise && can_start && (ioctl_index != IDX_ROM);

    // A write arriving together with the download rise already belongs to the
    // new download, so the un-latched index is used for that one cycle.
    assign rom_active = start_rom || (state == LOAD_ROM);
    assign aux_active = start_aux || (state == LOAD_AUX);
    assign wr_idx     = start_aux ? ioctl_index : idx_q;

    assign rom_accept = ioctl_wr && rom_active && (ioctl_addr <  {8'h00, ROM_SIZE});
    assign rom_reject = ioctl_wr && rom_active && (ioctl_addr >= {8'h00, ROM_SIZE});

    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path through the block can leave it unassigned and infer a latch.
    always_comb begin
        count_next = start_rom ? 17'd0 : byte_count;
        err_next   = start_rom ? 1'b0  : rom_err;
        if (rom_accept && (count_next != BYTE_COUNT_MAX)) begin
            count_next = count_next + 17'd1;
        end
        if (rom_reject) begin
            err_next = 1'b1;
        end
    end

    // The write on the falling cycle counts, hence count_next rather than
    // byte_count when deciding whether the load was empty.
    assign rom_end     = (state == LOAD_ROM) && dl_fall;
    assign rom_to_idle = rom_end && (count_next == '0) && (ret_state != HOLD);

    dl_hold_timer #(
        .HOLD_CYCLES (HOLD_CYCLES)
    ) u_hold_timer (
        .clock_12mhz (clock_12mhz),
        .reset       (reset),
        .load        (rom_end),
        .en          ((state == HOLD) && !dl_rise),
        .done        (hold_done)
    );

    always_ff @(posedge clock_12mhz or posedge reset) begin
        if (reset) begin
            state      <= HOLD;
            ret_state  <= IDLE;
            dl_prev    <= 1'b0;
            idx_q      <= 8'h00;
            core_reset <= 1'b1;
            dn_wr      <= 1'b0;
            dn_addr    <= '0;
            dn_data    <= '0;
            mod        <= '0;
            mod_sbag   <= 1'b0;
            mod_pick   <= 1'b0;
            dipsw      <= '0;
            rom_err    <= 1'b0;
            byte_count <= '0;
        end else begin
            dl_prev    <= ioctl_download;
            dn_wr      <= rom_accept;
            byte_count <= count_next;
            rom_err    <= err_next;
            mod_sbag   <= (mod == MOD_SBAG);
            mod_pick   <= (mod == MOD_PICK);

            if (rom_accept) begin
                dn_addr <= ioctl_addr[16:0];
                dn_data <= ioctl_dout;
            end

            if (aux_active && ioctl_wr) begin
                if (wr_idx == IDX_MOD) begin
                    mod <= ioctl_dout;
                end else if ((wr_idx == IDX_DIP) && (ioctl_addr[24:3] == '0)) begin
                    dipsw[{ioctl_addr[2:0], 3'b000} +: 8] <= ioctl_dout;
                end
            end

            case (state)
                IDLE, RUN, HOLD: begin
                    if (start_rom) begin
                        state      <= LOAD_ROM;
                        ret_state  <= state;
                        idx_q      <= ioctl_index;
                        core_reset <= 1'b1;
                    end else if (start_aux) begin
                        state     <= LOAD_AUX;
                        ret_state <= state;
                        idx_q     <= ioctl_index;
                    end else if ((state == HOLD) && hold_done) begin
                        state      <= RUN;
                        core_reset <= 1'b0;
                    end
                end
                LOAD_ROM: begin
                    if (rom_to_idle) begin
                        state      <= IDLE;
                        core_reset <= 1'b0;
                    end else if (rom_end) begin
                        state <= HOLD;
                    end
                end
                LOAD_AUX: begin
                    if (dl_fall) begin
                        state <= ret_state;
                    end
                end
                default: begin
                    state <= HOLD;
                end
            endcase
        end
    end

`ifdef ROM_CHECKSUM_EN
    logic [15:0] sum_q;
    logic [15:0] sum_next;

    assign sum_next = (start_rom ? 16'h0000 : sum_q)
                    + (rom_accept ? {8'h00, ioctl_dout} : 16'h0000);

    always_ff @(posedge clock_12mhz or posedge reset) begin
        if (reset) begin
            sum_q  <= '0;
            sum_ok <= 1'b0;
        end else begin
            sum_q <= sum_next;
            if (start_rom) begin
                sum_ok <= 1'b0;
            end else if (rom_end && !rom_to_idle) begin
                sum_ok <= (sum_next == EXPECTED_SUM) && !err_next;
            end
        end
    end
`else
    // Reference sum is meaningless without the checksum logic.
    logic unused_expected_sum;
    assign unused_expected_sum = ^EXPECTED_SUM;
    assign sum_ok = 1'b0;
`endif

endmodule

// File: tb/tb_rom_download_ctrl.sv
// ----------------------------------------------------------------------------
// tb_rom_download_ctrl
// Self-checking bench for rom_download_ctrl: directed scenarios followed by
// randomized downloads, compared against a transaction-level reference model.
// ----------------------------------------------------------------------------
module tb_rom_download_ctrl;

    localparam logic [16:0] ROM_SIZE = 17'h14000;
    localparam int          HOLD     = 1024;
    localparam logic [15:0] EXP_SUM  = 16'h0033;

    logic        clock_12mhz = 1'b0;
    logic        reset = 1'b1;
    logic        ioctl_download = 1'b0;
    logic        ioctl_wr = 1'b0;
    logic [24:0] ioctl_addr = '0;
    logic [7:0]  ioctl_dout = '0;
    logic [7:0]  ioctl_index = '0;
    logic [16:0] dn_addr;
    logic [7:0]  dn_data;
    logic        dn_wr;
    logic        core_reset;
    logic [7:0]  mod;
    logic        mod_sbag;
    logic        mod_pick;
    logic [63:0] dipsw;
    logic        rom_err;
    logic [16:0] byte_count;
    logic        sum_ok;

    rom_download_ctrl #(
        .ROM_SIZE     (ROM_SIZE),
        .HOLD_CYCLES  (HOLD),
        .EXPECTED_SUM (EXP_SUM)
    ) dut (
        .clock_12mhz    (clock_12mhz),
        .reset          (reset),
        .ioctl_download (ioctl_download),
        .ioctl_wr       (ioctl_wr),
        .ioctl_addr     (ioctl_addr),
        .ioctl_dout     (ioctl_dout),
        .ioctl_index    (ioctl_index),
        .dn_addr        (dn_addr),
        .dn_data        (dn_data),
        .dn_wr          (dn_wr),
        .core_reset     (core_reset),
        .mod            (mod),
        .mod_sbag       (mod_sbag),
        .mod_pick       (mod_pick),
        .dipsw          (dipsw),
        .rom_err        (rom_err),
        .byte_count     (byte_count),
        .sum_ok         (sum_ok)
    );

    initial forever #5 clock_12mhz = ~clock_12mhz;

    int cyc = 0;
    always @(posedge clock_12mhz) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int          at;
        logic [16:0] a;
        logic [7:0]  d;
    } dn_t;

    dn_t         dn_q[$];
    int          m_count;
    bit          m_err;
    logic [7:0]  m_mod;
    logic [7:0]  m_dip[8];
    logic [15:0] m_sum;
    bit          m_sum_ok;
    bit          last_dl;
    logic [7:0]  cur_idx;

    task automatic model_reset();
        m_count  = 0;
        m_err    = 0;
        m_mod    = 8'h00;
        m_sum    = 16'h0000;
        m_sum_ok = 0;
        last_dl  = 0;
        cur_idx  = 8'h00;
        for (int i = 0; i < 8; i++) m_dip[i] = 8'h00;
        dn_q.delete();
    endtask

    task automatic model_write(input logic [7:0] ix, input logic [24:0] a, input logic [7:0] d);
        dn_t e;
        if (ix == 8'd0) begin
            if (a < 25'(ROM_SIZE)) begin
                e.at = cyc + 1;
                e.a  = a[16:0];
                e.d  = d;
                dn_q.push_back(e);
                if (m_count < 17'h1FFFF) m_count++;
                m_sum = m_sum + 16'(d);
            end else begin
                m_err = 1;
            end
        end else if (ix == 8'd1) begin
            m_mod = d;
        end else if (ix == 8'd254 && a < 25'd8) begin
            m_dip[a[2:0]] = d;
        end
    endtask

    function automatic logic [63:0] dip_model();
        logic [63:0] v;
        for (int i = 0; i < 8; i++) v[8*i +: 8] = m_dip[i];
        return v;
    endfunction

    // ---------------- dn_wr monitor ----------------
    always @(negedge clock_12mhz) begin
        if (dn_wr === 1'b1) begin
            if (dn_q.size() == 0) begin
                check("dn_wr_spurious", dn_wr, 1'b0);
            end else begin
                dn_t e;
                e = dn_q.pop_front();
                check("dn_wr_cycle", cyc, e.at);
                check("dn_addr", dn_addr, e.a);
                check("dn_data", dn_data, e.d);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clock_12mhz);
        #1;
    endtask

    task automatic drive(input bit dl, input bit wr, input logic [24:0] a,
                         input logic [7:0] d, input logic [7:0] ix);
        ioctl_download = dl;
        ioctl_wr       = wr;
        ioctl_addr     = a;
        ioctl_dout     = d;
        ioctl_index    = ix;
        if (dl && !last_dl) begin
            cur_idx = ix;
            if (ix == 8'd0) begin
                m_count  = 0;
                m_err    = 0;
                m_sum    = 0;
                m_sum_ok = 0;
            end
        end
        if (wr && (dl || last_dl)) model_write(cur_idx, a, d);
        last_dl = dl;
        step();
    endtask

    task automatic check_regs(input string tag);
        check({tag, "_byte_count"}, byte_count, 17'(m_count));
        check({tag, "_rom_err"}, rom_err, m_err);
        check({tag, "_mod"}, mod, m_mod);
        check({tag, "_mod_sbag"}, mod_sbag, m_mod == 8'd1);
        check({tag, "_mod_pick"}, mod_pick, m_mod == 8'd2);
        check({tag, "_dipsw"}, dipsw, dip_model());
        check({tag, "_sum_ok"}, sum_ok, m_sum_ok);
        check({tag, "_dn_pending"}, dn_q.size(), 0);
    endtask

    // Counts clock edges until core_reset drops, bounded.
    task automatic wait_release(input string tag);
        int n = 0;
        while (core_reset === 1'b1 && n < HOLD + 64) begin
            step();
            n++;
        end
        check(tag, n, HOLD);
    endtask

    // Called right after the falling-edge cycle of a download.
    task automatic finish_download(input string tag, input logic [7:0] ix);
        if (ix == 8'd0) begin
`ifdef ROM_CHECKSUM_EN
            if (m_count != 0) m_sum_ok = (m_sum == EXP_SUM) && !m_err;
`else
            m_sum_ok = 0;
`endif
            if (m_count == 0) begin
                check({tag, "_core_reset_idle"}, core_reset, 1'b0);
                step();
            end else begin
                check({tag, "_core_reset_held"}, core_reset, 1'b1);
                wait_release({tag, "_hold_len"});
            end
        end else begin
            step();
            step();
            check({tag, "_core_reset_aux"}, core_reset, 1'b0);
        end
        check_regs(tag);
    endtask

    logic [24:0] wa[16];
    logic [7:0]  wd[16];
    int          wg[16];

    // One download of n writes from wa/wd with wg idle cycles before each.
    task automatic download(input string tag, input logic [7:0] ix, input int n,
                            input bit wr_rise, input bit wr_fall);
        int  k = 0;
        bit  fell = 0;
        logic [7:0] junk;
        if (wr_rise && n > 0) begin
            drive(1, 1, wa[0], wd[0], ix);
            k = 1;
        end else begin
            drive(1, 0, '0, '0, ix);
        end
        check({tag, "_core_reset_start"}, core_reset, ix == 8'd0);
        while (k < n) begin
            junk = 8'($urandom);
            for (int g = 0; g < wg[k]; g++) drive(1, 0, '0, '0, junk);
            if (k == n - 1 && wr_fall) begin
                drive(0, 1, wa[k], wd[k], junk);
                fell = 1;
            end else begin
                drive(1, 1, wa[k], wd[k], junk);
            end
            k++;
        end
        if (!fell) drive(0, 0, '0, '0, 8'($urandom));
        finish_download(tag, ix);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        logic [7:0] ix;
        int         n;
        model_reset();
        reset = 1'b1;
        repeat (3) step();
        check("rst_core_reset", core_reset, 1'b1);
        check("rst_dn_wr", dn_wr, 1'b0);
        check("rst_dn_addr", dn_addr, 17'h0);
        check("rst_dn_data", dn_data, 8'h0);
        check_regs("rst");
        reset = 1'b0;
        wait_release("rst_hold_len");

        // Variant byte: mod updates after the write, decodes one cycle later.
        drive(1, 1, 25'd0, 8'h01, 8'd1);
        check("mod_written", mod, 8'h01);
        check("mod_sbag_lag", mod_sbag, 1'b0);
        drive(1, 0, '0, '0, 8'd77);
        check("mod_sbag_set", mod_sbag, 1'b1);
        check("mod_pick_clr", mod_pick, 1'b0);
        drive(0, 0, '0, '0, 8'd77);
        finish_download("mod", 8'd1);

        // Two back-to-back ROM bytes; sum 0x33.
        wa[0] = 25'd0; wd[0] = 8'h11; wg[0] = 0;
        wa[1] = 25'd1; wd[1] = 8'h22; wg[1] = 0;
        download("rom_b2b", 8'd0, 2, 0, 0);

        // Same with 0x23: sum 0x34, no match.
        wd[1] = 8'h23;
        download("rom_sum_bad", 8'd0, 2, 0, 0);

        // Only an out-of-range byte: nothing accepted, core goes straight idle.
        wa[0] = 25'h14000; wd[0] = 8'h99; wg[0] = 0;
        download("rom_oor", 8'd0, 1, 0, 0);

        // Last valid address plus an out-of-range byte on the falling cycle.
        wa[0] = 25'h13FFF; wd[0] = 8'h5A; wg[0] = 0;
        wa[1] = 25'h14000; wd[1] = 8'h66; wg[1] = 1;
        download("rom_edge", 8'd0, 2, 1, 1);

        // A clean load clears the sticky error.
        wa[0] = 25'd4; wd[0] = 8'h11; wg[0] = 0;
        wa[1] = 25'd5; wd[1] = 8'h22; wg[1] = 2;
        download("rom_clear", 8'd0, 2, 0, 1);

        // DIP bank: bytes 0 and 7 land, 8 and 9 are ignored.
        wa[0] = 25'd0; wd[0] = 8'hF0; wg[0] = 0;
        wa[1] = 25'd9; wd[1] = 8'h55; wg[1] = 0;
        wa[2] = 25'd7; wd[2] = 8'hA5; wg[2] = 1;
        wa[3] = 25'd8; wd[3] = 8'h3C; wg[3] = 0;
        download("dip", 8'd254, 4, 1, 0);

        // Reset in the middle of a ROM load.
        drive(1, 0, '0, '0, 8'd0);
        drive(1, 1, 25'd5, 8'h77, 8'd3);
        drive(1, 0, '0, '0, 8'd3);
        reset = 1'b1;
        ioctl_download = 1'b0;
        ioctl_wr = 1'b0;
        #2;
        model_reset();
        check("midrst_core_reset", core_reset, 1'b1);
        check("midrst_dn_addr", dn_addr, 17'h0);
        check_regs("midrst");
        step();
        reset = 1'b0;
        wait_release("midrst_hold_len");

        // Randomized downloads.
        for (int t = 0; t < 14; t++) begin
            case ($urandom_range(0, 3))
                0:       ix = 8'd0;
                1:       ix = 8'd1;
                2:       ix = 8'd254;
                default: ix = 8'($urandom_range(2, 253));
            endcase
            n = $urandom_range(1, 5);
            for (int k = 0; k < n; k++) begin
                wd[k] = 8'($urandom);
                wg[k] = $urandom_range(0, 2);
                if (ix == 8'd0) begin
                    case ($urandom_range(0, 9))
                        8:       wa[k] = 25'(ROM_SIZE) + 25'($urandom_range(0, 3));
                        9:       wa[k] = 25'($urandom);
                        default: wa[k] = 25'($urandom_range(0, 32'(ROM_SIZE) - 1));
                    endcase
                end else begin
                    wa[k] = 25'($urandom_range(0, 11));
                end
            end
            download("rnd", ix, n, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1);
    end

endmodule
